// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register: 2-entry skid buffer with valid/ready handshakes and synchronous flush.
// Optional stall counter output stall_cnt_o when EX_MEM_STALL_CNT_EN is defined.
module ex_mem_reg #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              ex_valid_i,
  output logic              ex_ready_o,
  input  logic              ex_we_i,
  input  logic [ADDR_W-1:0] ex_waddr_i,
  input  logic [DATA_W-1:0] ex_wdata_i,
  output logic              mem_valid_o,
  input  logic              mem_ready_i,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_waddr_o,
`ifdef EX_MEM_STALL_CNT_EN
  output logic [31:0]       stall_cnt_o,
`endif
  output logic [DATA_W-1:0] mem_wdata_o
);

  logic              main_valid_q, main_valid_d;
  logic              main_we_q, main_we_d;
  logic [ADDR_W-1:0] main_waddr_q, main_waddr_d;
  logic [DATA_W-1:0] main_wdata_q, main_wdata_d;
  logic              skid_valid_q, skid_valid_d;
  logic              skid_we_q, skid_we_d;
  logic [ADDR_W-1:0] skid_waddr_q, skid_waddr_d;
  logic [DATA_W-1:0] skid_wdata_q, skid_wdata_d;
  logic              xfer_in, xfer_out;

  // Ready depends only on stored state, so no combinational path from mem_ready_i.
  assign ex_ready_o  = ~skid_valid_q & ~rst;
  assign xfer_in     = ex_valid_i & ex_ready_o;
  assign xfer_out    = main_valid_q & mem_ready_i;

  assign mem_valid_o = main_valid_q;
  assign mem_we_o    = main_we_q & main_valid_q;
  assign mem_waddr_o = main_waddr_q;
  assign mem_wdata_o = main_wdata_q;

  always_comb begin
    main_valid_d = main_valid_q;
    main_we_d    = main_we_q;
    main_waddr_d = main_waddr_q;
    main_wdata_d = main_wdata_q;
    skid_valid_d = skid_valid_q;
    skid_we_d    = skid_we_q;
    skid_waddr_d = skid_waddr_q;
    skid_wdata_d = skid_wdata_q;
    if (flush_i) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q) begin
      if (xfer_in) begin
        main_valid_d = 1'b1;
        main_we_d    = ex_we_i;
        main_waddr_d = ex_waddr_i;
        main_wdata_d = ex_wdata_i;
      end
    end else if (xfer_out) begin
      if (skid_valid_q) begin
        main_we_d    = skid_we_q;
        main_waddr_d = skid_waddr_q;
        main_wdata_d = skid_wdata_q;
        skid_valid_d = 1'b0;
      end else if (xfer_in) begin
        main_we_d    = ex_we_i;
        main_waddr_d = ex_waddr_i;
        main_wdata_d = ex_wdata_i;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (xfer_in) begin
      skid_valid_d = 1'b1;
      skid_we_d    = ex_we_i;
      skid_waddr_d = ex_waddr_i;
      skid_wdata_d = ex_wdata_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      main_we_q    <= 1'b0;
      main_waddr_q <= '0;
      main_wdata_q <= '0;
      skid_valid_q <= 1'b0;
      skid_we_q    <= 1'b0;
      skid_waddr_q <= '0;
      skid_wdata_q <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_we_q    <= main_we_d;
      main_waddr_q <= main_waddr_d;
      main_wdata_q <= main_wdata_d;
      skid_valid_q <= skid_valid_d;
      skid_we_q    <= skid_we_d;
      skid_waddr_q <= skid_waddr_d;
      skid_wdata_q <= skid_wdata_d;
    end
  end

`ifdef EX_MEM_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  // Saturating; flush does not touch it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (main_valid_q && !mem_ready_i && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ex_mem_reg.sv
// Bench for ex_mem_reg: directed steps plus random traffic against a 2-deep FIFO reference model.
module tb_ex_mem_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush_i;
  logic        ex_valid_i;
  logic        ex_ready_o;
  logic        ex_we_i;
  logic [4:0]  ex_waddr_i;
  logic [31:0] ex_wdata_i;
  logic        mem_valid_o;
  logic        mem_ready_i;
  logic        mem_we_o;
  logic [4:0]  mem_waddr_o;
  logic [31:0] mem_wdata_o;
`ifdef EX_MEM_STALL_CNT_EN
  logic [31:0] stall_cnt_o;
`endif

  ex_mem_reg #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (flush_i),
    .ex_valid_i (ex_valid_i),
    .ex_ready_o (ex_ready_o),
    .ex_we_i    (ex_we_i),
    .ex_waddr_i (ex_waddr_i),
    .ex_wdata_i (ex_wdata_i),
    .mem_valid_o(mem_valid_o),
    .mem_ready_i(mem_ready_i),
    .mem_we_o   (mem_we_o),
    .mem_waddr_o(mem_waddr_o),
`ifdef EX_MEM_STALL_CNT_EN
    .stall_cnt_o(stall_cnt_o),
`endif
    .mem_wdata_o(mem_wdata_o)
  );

  always #5 clk = ~clk;

  // Reference model: FIFO of {we, waddr, wdata} with capacity 2.
  logic [37:0] mq[$];
  logic [31:0] stall_m;
  int          n_cmp;
  int          n_fail;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".ready"}, {31'd0, ex_ready_o}, {31'd0, mq.size() < 2});
    chk({tag, ".valid"}, {31'd0, mem_valid_o}, {31'd0, mq.size() > 0});
    if (mq.size() > 0) begin
      chk({tag, ".we"},    {31'd0, mem_we_o},    {31'd0, mq[0][37]});
      chk({tag, ".waddr"}, {27'd0, mem_waddr_o}, {27'd0, mq[0][36:32]});
      chk({tag, ".wdata"}, mem_wdata_o, mq[0][31:0]);
    end else begin
      chk({tag, ".we_empty"}, {31'd0, mem_we_o}, 32'd0);
    end
`ifdef EX_MEM_STALL_CNT_EN
    chk({tag, ".stall"}, stall_cnt_o, stall_m);
`endif
  endtask

  // Called at a negedge: drive inputs, advance model at the posedge, check at the next negedge.
  task automatic cyc(input string tag, input bit v, input bit we, input logic [4:0] a,
                     input logic [31:0] d, input bit mr, input bit fl);
    int n;
    bit acc, pop;
    ex_valid_i  = v;
    ex_we_i     = we;
    ex_waddr_i  = a;
    ex_wdata_i  = d;
    mem_ready_i = mr;
    flush_i     = fl;
    n   = mq.size();
    acc = v && (n < 2);
    pop = (n > 0) && mr;
    @(posedge clk);
    if (fl) begin
      mq.delete();
    end else begin
      if (pop) void'(mq.pop_front());
      if (acc) mq.push_back({we, a, d});
    end
    if ((n > 0) && !mr && (stall_m != 32'hFFFF_FFFF)) stall_m++;
    @(negedge clk);
    check_model(tag);
  endtask

  task automatic idle(input string tag, input bit mr);
    cyc(tag, 1'b0, 1'b0, 5'd0, 32'd0, mr, 1'b0);
  endtask

  initial begin
    n_cmp = 0; n_fail = 0; stall_m = 0;
    rst = 1'b1; flush_i = 1'b0; ex_valid_i = 1'b0; ex_we_i = 1'b0;
    ex_waddr_i = '0; ex_wdata_i = '0; mem_ready_i = 1'b0;
    #1;
    chk("rst.ready", {31'd0, ex_ready_o}, 32'd0);
    chk("rst.valid", {31'd0, mem_valid_o}, 32'd0);
    chk("rst.we",    {31'd0, mem_we_o}, 32'd0);
    chk("rst.waddr", {27'd0, mem_waddr_o}, 32'd0);
    chk("rst.wdata", mem_wdata_o, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_model("post_rst");

    // Streaming with mem_ready held high.
    cyc("s1", 1'b1, 1'b1, 5'd3, 32'h0000_1234, 1'b1, 1'b0);
    chk("s1.waddr3", {27'd0, mem_waddr_o}, 32'd3);
    cyc("s2", 1'b1, 1'b1, 5'd4, 32'hFFFF_0000, 1'b1, 1'b0);
    chk("s2.wdata", mem_wdata_o, 32'hFFFF_0000);
    idle("s3", 1'b1);
    chk("s3.empty", {31'd0, mem_valid_o}, 32'd0);

    // Backpressure: A, B fill both slots, C held off until drain.
    cyc("bp_a", 1'b1, 1'b1, 5'd1, 32'hAAAA_0001, 1'b0, 1'b0);
    cyc("bp_b", 1'b1, 1'b1, 5'd2, 32'hBBBB_0002, 1'b0, 1'b0);
    chk("bp.ready_low", {31'd0, ex_ready_o}, 32'd0);
    cyc("bp_c0", 1'b1, 1'b1, 5'd7, 32'hCCCC_0007, 1'b0, 1'b0);
    chk("bp.a_held", {27'd0, mem_waddr_o}, 32'd1);
    for (int i = 0; i < 3; i++) cyc("bp_c", 1'b1, 1'b1, 5'd7, 32'hCCCC_0007, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) idle("bp_drain", 1'b1);

    // Flush with both slots full and an input presented.
    cyc("fl_a", 1'b1, 1'b1, 5'd10, 32'h1111_1111, 1'b0, 1'b0);
    cyc("fl_b", 1'b1, 1'b1, 5'd11, 32'h2222_2222, 1'b0, 1'b0);
    cyc("fl", 1'b1, 1'b1, 5'd12, 32'h3333_3333, 1'b1, 1'b1);
    chk("fl.ready", {31'd0, ex_ready_o}, 32'd1);
    chk("fl.we", {31'd0, mem_we_o}, 32'd0);
    for (int i = 0; i < 2; i++) idle("fl_after", 1'b1);

    // Asynchronous reset between edges with both slots held.
    cyc("ar_a", 1'b1, 1'b1, 5'd20, 32'h5555_5555, 1'b0, 1'b0);
    cyc("ar_b", 1'b1, 1'b1, 5'd21, 32'h6666_6666, 1'b0, 1'b0);
    ex_valid_i = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("ar.valid", {31'd0, mem_valid_o}, 32'd0);
    chk("ar.we",    {31'd0, mem_we_o}, 32'd0);
    chk("ar.waddr", {27'd0, mem_waddr_o}, 32'd0);
    chk("ar.wdata", mem_wdata_o, 32'd0);
    chk("ar.ready", {31'd0, ex_ready_o}, 32'd0);
    mq.delete();
    stall_m = 0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_model("ar_rel");
    cyc("ar_lat", 1'b1, 1'b1, 5'd22, 32'h7777_7777, 1'b1, 1'b0);
    chk("ar_lat.valid", {31'd0, mem_valid_o}, 32'd1);
    idle("ar_drain", 1'b1);

    // Write-enable guard and we=0 pass-through.
    cyc("we0", 1'b1, 1'b0, 5'd9, 32'hDEAD_BEEF, 1'b1, 1'b0);
    chk("we0.we", {31'd0, mem_we_o}, 32'd0);
    chk("we0.data", mem_wdata_o, 32'hDEAD_BEEF);
    idle("we0_drain", 1'b1);

    // Stall accounting: one entry held for 7 cycles, flush, then reset.
    cyc("st_load", 1'b1, 1'b1, 5'd15, 32'h0F0F_0F0F, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) idle("st_hold", 1'b0);
    cyc("st_flush", 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1);
`ifdef EX_MEM_STALL_CNT_EN
    chk("st.after_flush", stall_cnt_o, 32'd7);
    rst = 1'b1;
    #1;
    chk("st.rst", stall_cnt_o, 32'd0);
    mq.delete();
    stall_m = 0;
    @(negedge clk);
    rst = 1'b0;
    #1;
`endif

    // Random traffic with occasional flushes.
    for (int i = 0; i < 400; i++) begin
      cyc("rnd", ($urandom_range(0, 3) != 0), $urandom_range(0, 1) != 0,
          5'($urandom_range(0, 31)), $urandom, ($urandom_range(0, 2) != 0),
          ($urandom_range(0, 24) == 0));
    end
    for (int i = 0; i < 3; i++) idle("final_drain", 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_mem_reg.md
Name: ex_mem_reg

Overview:
- Pipeline register between the execute stage and the memory-access stage of the 5-stage integer pipeline.
- Captures the execute result (write enable, destination register address, write data) and presents it to the memory stage one cycle later.
- Uses a 2-entry skid buffer with valid/ready handshakes, so memory-stage backpressure never drops or reorders a result and never creates a combinational ready path back into execute.
- Also supports a synchronous flush for exception and branch squash.

Parameters:
- DATA_W, 32, width of register write data (RegBus)
- ADDR_W, 5, width of register file address (RegAddrBus)

Ports:
- clk  in  1  pipeline clock, rising-edge
- rst  in  1  reset, asynchronous, active-high
- flush_i  in  1  synchronous squash of all held entries
- ex_valid_i  in  1  execute stage presents a result this cycle
- ex_ready_o  out  1  this block can accept a result this cycle
- ex_we_i  in  1  result write enable from execute
- ex_waddr_i  in  ADDR_W  destination register address from execute
- ex_wdata_i  in  DATA_W  result data from execute
- mem_valid_o  out  1  an entry is presented to the memory stage
- mem_ready_i  in  1  memory stage consumes the presented entry
- mem_we_o  out  1  write enable to the memory stage; forced 0 when mem_valid_o=0
- mem_waddr_o  out  ADDR_W  destination address of the presented entry
- mem_wdata_o  out  DATA_W  data of the presented entry

Behaviour:
- Storage: main entry {valid, we, waddr, wdata} drives mem_*; skid entry has the same fields.
- Transfer in: ex_valid_i & ex_ready_o. Transfer out: mem_valid_o & mem_ready_i.
- Reset (rst=1, asynchronous):
  - both valid bits, we, waddr and wdata clear to 0;
  - mem_valid_o=0, mem_we_o=0, mem_waddr_o=0, mem_wdata_o=0;
  - ex_ready_o=0 while rst is high.
  - Reset asserted mid-transfer discards all entries immediately.
- ex_ready_o = ~skid.valid, taken from a register only (no combinational path from mem_ready_i).
- Next state on the rising clock edge, when rst=0 and flush_i=0:
  - main empty: a transfer-in loads main. Latency is 1 cycle from ex_valid_i to mem_valid_o.
  - main full, transfer out, skid full: skid moves to main and skid empties. No transfer-in is possible because ready=0.
  - main full, transfer out, skid empty: a transfer-in loads main; otherwise main empties.
  - main full, no transfer out: a transfer-in loads skid; otherwise hold.
- Throughput is 1 entry/cycle with mem_ready_i held at 1.
- Ordering is strictly FIFO. An entry is never duplicated or lost.
- Held entries keep all fields stable while mem_valid_o=1 and mem_ready_i=0.
- Flush (flush_i=1 at a clock edge, rst=0):
  - both valid bits clear;
  - the input presented that cycle is discarded even if ex_valid_i=1;
  - ex_ready_o=1 on the next cycle;
  - flush has priority over every transfer in the same cycle.
- mem_we_o = main.we & main.valid, so no spurious register write leaves an empty slot.
- ex_we_i=0 entries are still valid entries and are carried in order.

Optional Feature:
- Macro: EX_MEM_STALL_CNT_EN.
- Defined:
  - adds output port stall_cnt_o (32 bits);
  - increments each cycle mem_valid_o=1 and mem_ready_i=0;
  - saturates at 32'hFFFF_FFFF;
  - resets to 0 on rst only and is unaffected by flush_i.
- Undefined: the port and counter logic are absent; all other behaviour is identical.

Test Plan:
- Reset then stream: mem_ready_i=1, send {we=1,waddr=5'd3,wdata=32'h0000_1234} then {1,5'd4,32'hFFFF_0000} on consecutive cycles -> each appears on mem_* exactly 1 cycle later, mem_valid_o high 2 cycles, ex_ready_o stays 1.
- Backpressure: mem_ready_i=0, send A (waddr=1), B (waddr=2) -> ex_ready_o drops to 0 after B, C is held off. Raise mem_ready_i -> A, B, C emerge in order, one per cycle, no loss or duplication.
- Flush with both entries full and ex_valid_i=1 -> next cycle mem_valid_o=0, mem_we_o=0, ex_ready_o=1, and the flushed input never appears.
- Async reset mid-stall: assert rst between clock edges with 2 entries held -> mem_valid_o, mem_we_o, mem_waddr_o, mem_wdata_o go 0 immediately; after release, the first accepted entry has 1-cycle latency.
- Empty-slot write guard: main holding we=1, then drained with no new input -> mem_we_o=0 whenever mem_valid_o=0. An entry with we=0, wdata=32'hDEAD_BEEF passes through with mem_we_o=0.
- With EX_MEM_STALL_CNT_EN defined: hold mem_ready_i=0 for 7 cycles with 1 entry held -> stall_cnt_o=7; a flush leaves 7; rst clears it to 0.
